// File: rtl/qbus_pkg.sv
// Shared types and helpers for the Q-bus responder: FSM states, strobe
// bit positions in the synchronizer vector, and the window hit compare.
package qbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_NOSEL,
    S_RD,
    S_WR,
    S_DLY,
    S_RPLY,
    S_IACK
  } state_t;

  // Bit positions of the active-high strobes after synchronization
  localparam int STB_SYNC = 0;
  localparam int STB_DIN  = 1;
  localparam int STB_DOUT = 2;
  localparam int STB_WTBT = 3;
  localparam int STB_IAKO = 4;
  localparam int STB_INIT = 5;
  localparam int STB_N    = 6;

  // True when addr falls in the 2**(aw+1)-byte window starting at base
  function automatic logic addr_hit(input logic [21:0] addr,
                                    input logic [21:0] base,
                                    input int          aw);
    logic [21:0] mask;
    mask = ~((22'd1 << (aw + 1)) - 22'd1);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/qbus_sync.sv
// Two-flop synchronizer vector for asynchronous bus strobes.
module qbus_sync #(
  parameter int W = 1
) (
  input  logic         pin_clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages; reset clears to the deasserted level
  always_ff @(posedge pin_clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qbus_resp.sv
// Q-bus target: decodes an address window, serves DATI/DATO(B)/DATIO(B)
// from a one-cycle-latency memory port and answers IAKO with a vector.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for SYNC edge or an interrupt acknowledge
// SEL   | addressed; waiting for DIN or DOUT
// NOSEL | not addressed; waiting for SYNC to negate
// RD    | phase 0 strobes mem_re, phase 1 captures mem_rdata
// WR    | strobes mem_we with captured data and byte enables
// DLY   | inserts RDLY wait cycles before replying
// RPLY  | RPLY asserted (plus AD on reads) until the strobe negates
// IACK  | RPLY and vector on AD until DIN negates
module qbus_resp
  import qbus_pkg::*;
#(
  parameter logic [21:0] BASE   = 22'o17760000,
  parameter int          AW     = 12,
  parameter int          IOPAGE = 1,
  parameter logic [15:0] VECTOR = 16'o000300,
  parameter int          RDLY   = 2
) (
  input  logic          pin_clk,
  input  logic          reset,
  input  logic          pin_init_n,
  inout  wire  [15:0]   pin_ad_n,
  input  logic [5:0]    pin_a_n,
  input  logic          pin_bs_n,
  input  logic          pin_sync_n,
  input  logic          pin_din_n,
  input  logic          pin_dout_n,
  input  logic          pin_wtbt_n,
  input  logic          pin_iako_n,
  output logic          pin_rply_n,
  output logic          pin_virq_n,
  input  logic          irq_set,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_be,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [15:0]   mem_rdata
);

  logic [STB_N-1:0] stb_raw, stb_s;
  logic sync_s, din_s, dout_s, wtbt_s, iako_s, init_s;
  logic sync_d, sync_rise, abort, hit;
  logic [21:0] pin_addr;
  logic [15:0] pin_data, data, ad_val;
  state_t state, nxt;
  logic rd_ph, rd_cyc, a0, pend;
  logic [3:0] cnt;
  logic rply_on, ad_on;

  assign stb_raw = ~{pin_init_n, pin_iako_n, pin_wtbt_n, pin_dout_n, pin_din_n, pin_sync_n};

  qbus_sync #(.W(STB_N)) u_sync (
    .pin_clk (pin_clk),
    .reset   (reset),
    .d       (stb_raw),
    .q       (stb_s)
  );

  assign sync_s    = stb_s[STB_SYNC];
  assign din_s     = stb_s[STB_DIN];
  assign dout_s    = stb_s[STB_DOUT];
  assign wtbt_s    = stb_s[STB_WTBT];
  assign iako_s    = stb_s[STB_IAKO];
  assign init_s    = stb_s[STB_INIT];
  assign abort     = reset | init_s;
  assign sync_rise = sync_s & ~sync_d;
  assign pin_addr  = ~{pin_a_n, pin_ad_n};
  assign pin_data  = ~pin_ad_n;
  assign hit       = addr_hit(pin_addr, BASE, AW) && ((IOPAGE == 0) || !pin_bs_n);

  // State register; INIT behaves as a synchronous abort
  always_ff @(posedge pin_clk) begin
    if (abort) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic; SYNC negation ends any addressed cycle
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (sync_rise)                                nxt = hit ? S_SEL : S_NOSEL;
        else if (iako_s && din_s && !sync_s && pend)  nxt = S_IACK;
      end
      S_SEL: begin
        if (din_s && !dout_s)      nxt = S_RD;
        else if (dout_s && !din_s) nxt = S_WR;
      end
      S_RD:    if (rd_ph) nxt = (RDLY == 0) ? S_RPLY : S_DLY;
      S_WR:    nxt = (RDLY == 0) ? S_RPLY : S_DLY;
      S_DLY:   if (cnt == 4'd0) nxt = S_RPLY;
      S_RPLY:  if (!(rd_cyc ? din_s : dout_s)) nxt = S_SEL;
      S_IACK:  if (!din_s) nxt = S_IDLE;
      default: nxt = state;
    endcase
    if (!sync_s && state != S_IDLE && state != S_IACK) nxt = S_IDLE;
  end

  // Address/data capture, read phase, delay counter
  always_ff @(posedge pin_clk) begin
    if (reset) begin
      sync_d    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      a0        <= 1'b0;
      data      <= '0;
      rd_ph     <= 1'b0;
      rd_cyc    <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_d <= sync_s;
      rd_ph  <= (state == S_RD) && !rd_ph;
      if (state == S_IDLE && sync_rise) begin
        mem_addr <= pin_addr[AW:1];
        a0       <= pin_addr[0];
      end
      if (state == S_RD && rd_ph) data <= mem_rdata;
      if (state == S_SEL && nxt == S_RD) rd_cyc <= 1'b1;
      if (state == S_SEL && nxt == S_WR) begin
        rd_cyc <= 1'b0;
        // Byte data arrives on the low lane and is copied to both lanes
        if (wtbt_s) begin
          mem_wdata <= {pin_data[7:0], pin_data[7:0]};
          mem_be    <= a0 ? 2'b10 : 2'b01;
        end else begin
          mem_wdata <= pin_data;
          mem_be    <= 2'b11;
        end
      end
      if (nxt == S_DLY && state != S_DLY) cnt <= 4'(RDLY - 1);
      else if (state == S_DLY && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // Pending interrupt; a new request wins over the acknowledge clear
  always_ff @(posedge pin_clk) begin
    if (abort)                               pend <= 1'b0;
    else if (irq_set)                        pend <= 1'b1;
    else if (state == S_IDLE && nxt == S_IACK) pend <= 1'b0;
  end

  // Output decode from state
  always_comb begin
    mem_re  = (state == S_RD) && !rd_ph;
    mem_we  = (state == S_WR);
    rply_on = (state == S_RPLY) || (state == S_IACK);
    ad_on   = ((state == S_RPLY) && rd_cyc) || (state == S_IACK);
    ad_val  = (state == S_IACK) ? ~VECTOR : ~data;
  end

  assign pin_rply_n = rply_on ? 1'b0 : 1'bz;
  assign pin_ad_n   = ad_on ? ad_val : 16'bz;
  assign pin_virq_n = pend ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_qbus_resp.sv
// Directed bench for qbus_resp: bus master tasks, one-cycle memory model.
module tb_qbus_resp;

  logic        clk = 1'b0;
  logic        reset, init_n, sync_n, din_n, dout_n, wtbt_n, iako_n, bs_n, irq_set;
  logic [5:0]  a_n;
  logic        m_oe;
  logic [15:0] m_ad;
  wire  [15:0] ad_n;
  wire         rply_n, virq_n;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;
  logic        mem_we, mem_re;

  logic [15:0] mem [0:4095];
  int          re_cnt = 0, we_cnt = 0, rply_falls = 0;
  logic [11:0] last_re_addr = '0, last_we_addr = '0;
  logic [1:0]  last_be = '0;
  logic [15:0] last_wd = '0;
  logic        prev_rply = 1'b1;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (ad_n[i]);
  end
  pullup (rply_n);
  pullup (virq_n);

  assign ad_n = m_oe ? m_ad : 16'bz;

  qbus_resp #(.RDLY(2)) dut (
    .pin_clk    (clk),
    .reset      (reset),
    .pin_init_n (init_n),
    .pin_ad_n   (ad_n),
    .pin_a_n    (a_n),
    .pin_bs_n   (bs_n),
    .pin_sync_n (sync_n),
    .pin_din_n  (din_n),
    .pin_dout_n (dout_n),
    .pin_wtbt_n (wtbt_n),
    .pin_iako_n (iako_n),
    .pin_rply_n (rply_n),
    .pin_virq_n (virq_n),
    .irq_set    (irq_set),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // Memory model and strobe/reply monitors
  always @(posedge clk) begin
    prev_rply <= rply_n;
    if (prev_rply === 1'b1 && rply_n === 1'b0) rply_falls <= rply_falls + 1;
    if (mem_re) begin
      mem_rdata    <= mem[mem_addr];
      re_cnt       <= re_cnt + 1;
      last_re_addr <= mem_addr;
    end
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_be      <= mem_be;
      last_wd      <= mem_wdata;
      last_we_addr <= mem_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rply(input logic lvl, input int max, output int n);
    n = 0;
    while (rply_n !== lvl && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic addr_phase(input logic [21:0] a, input logic bs, input logic wt);
    m_ad   = ~a[15:0];
    m_oe   = 1'b1;
    a_n    = ~a[21:16];
    bs_n   = ~bs;
    wtbt_n = ~wt;
    tick(1);
    sync_n = 1'b0;
    tick(4);
    m_oe   = 1'b0;
    wtbt_n = 1'b1;
    bs_n   = 1'b1;
  endtask

  task automatic end_cycle();
    sync_n = 1'b1;
    tick(4);
  endtask

  initial begin
    int n, re0, we0, f0;
    reset = 1'b1; init_n = 1'b1; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
    wtbt_n = 1'b1; iako_n = 1'b1; bs_n = 1'b1; irq_set = 1'b0; a_n = '1;
    m_oe = 1'b0; m_ad = '0;
    mem[4] = 16'o123456;
    mem[5] = 16'o054321;
    tick(3);
    reset = 1'b0;
    tick(1);

    chk("rst_rply", rply_n, 1'b1);
    chk("rst_ad", ad_n, 16'hffff);
    chk("rst_virq", virq_n, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_re", mem_re, 1'b0);
    chk("rst_be", mem_be, 2'b00);
    chk("rst_addr", mem_addr, 12'd0);
    chk("rst_wdata", mem_wdata, 16'd0);

    // DATI word 4
    addr_phase(22'o17760010, 1'b1, 1'b0);
    din_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("dati_lat", n, 7);
    chk("dati_re_cnt", re_cnt, 1);
    chk("dati_re_addr", last_re_addr, 12'd4);
    chk("dati_ad", ad_n, 16'(~16'o123456));
    din_n = 1'b1;
    wait_rply(1'b1, 20, n);
    chk("dati_rel", n, 3);
    chk("dati_ad_rel", ad_n, 16'hffff);
    end_cycle();

    // DATOB to odd byte
    addr_phase(22'o17760011, 1'b1, 1'b1);
    m_ad = ~16'o000377; m_oe = 1'b1; wtbt_n = 1'b0;
    tick(1);
    dout_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("datob_lat", n, 6);
    chk("datob_we_cnt", we_cnt, 1);
    chk("datob_be", last_be, 2'b10);
    chk("datob_wdata", last_wd, 16'o177777);
    chk("datob_addr", last_we_addr, 12'd4);
    dout_n = 1'b1;
    wait_rply(1'b1, 20, n);
    chk("datob_rel", n, 3);
    m_oe = 1'b0; wtbt_n = 1'b1;
    end_cycle();

    // DATIO word 5
    re0 = re_cnt; we0 = we_cnt; f0 = rply_falls;
    addr_phase(22'o17760012, 1'b1, 1'b0);
    din_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("datio_ad", ad_n, 16'(~16'o054321));
    din_n = 1'b1;
    wait_rply(1'b1, 20, n);
    m_ad = ~16'o011111; m_oe = 1'b1;
    tick(1);
    dout_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("datio_w_lat", n, 6);
    dout_n = 1'b1;
    wait_rply(1'b1, 20, n);
    m_oe = 1'b0;
    end_cycle();
    chk("datio_re", re_cnt - re0, 1);
    chk("datio_we", we_cnt - we0, 1);
    chk("datio_be", last_be, 2'b11);
    chk("datio_wdata", last_wd, 16'o011111);
    chk("datio_addr", last_we_addr, 12'd5);
    chk("datio_rplys", rply_falls - f0, 2);

    // Address miss, then window hit with BS negated
    re0 = re_cnt; we0 = we_cnt;
    addr_phase(22'o00001000, 1'b1, 1'b0);
    din_n = 1'b0;
    tick(12);
    chk("miss_rply", rply_n, 1'b1);
    chk("miss_ad", ad_n, 16'hffff);
    din_n = 1'b1;
    end_cycle();
    addr_phase(22'o17760010, 1'b0, 1'b0);
    din_n = 1'b0;
    tick(12);
    chk("nobs_rply", rply_n, 1'b1);
    chk("nobs_ad", ad_n, 16'hffff);
    din_n = 1'b1;
    end_cycle();
    chk("miss_re", re_cnt, re0);
    chk("miss_we", we_cnt, we0);

    // Interrupt acknowledge
    irq_set = 1'b1;
    tick(1);
    irq_set = 1'b0;
    chk("irq_virq", virq_n, 1'b0);
    din_n = 1'b0; iako_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("iack_lat", n, 3);
    chk("iack_vec", ad_n, 16'(~16'o000300));
    chk("iack_pend_clr", virq_n, 1'b1);
    din_n = 1'b1; iako_n = 1'b1;
    wait_rply(1'b1, 20, n);
    chk("iack_rel", n, 3);
    chk("iack_ad_rel", ad_n, 16'hffff);
    tick(2);
    din_n = 1'b0; iako_n = 1'b0;
    tick(10);
    chk("iack2_norply", rply_n, 1'b1);
    din_n = 1'b1; iako_n = 1'b1;
    tick(4);

    // irq_set coinciding with IACK entry keeps pend
    irq_set = 1'b1;
    tick(1);
    irq_set = 1'b0;
    din_n = 1'b0; iako_n = 1'b0;
    tick(2);
    irq_set = 1'b1;
    tick(1);
    irq_set = 1'b0;
    chk("iack3_rply", rply_n, 1'b0);
    chk("iack3_pend", virq_n, 1'b0);
    din_n = 1'b1; iako_n = 1'b1;
    tick(4);

    // INIT during DLY of a read
    re0 = re_cnt;
    addr_phase(22'o17760010, 1'b1, 1'b0);
    din_n = 1'b0;
    tick(3);
    init_n = 1'b0;
    tick(3);
    chk("init_rply", rply_n, 1'b1);
    chk("init_ad", ad_n, 16'hffff);
    chk("init_virq", virq_n, 1'b1);
    tick(6);
    chk("init_norply", rply_n, 1'b1);
    chk("init_re", re_cnt - re0, 1);
    init_n = 1'b1; din_n = 1'b1;
    end_cycle();

    addr_phase(22'o17760010, 1'b1, 1'b0);
    din_n = 1'b0;
    wait_rply(1'b0, 20, n);
    chk("post_init_lat", n, 7);
    chk("post_init_ad", ad_n, 16'(~16'o123456));
    din_n = 1'b1;
    wait_rply(1'b1, 20, n);
    chk("post_init_rel", n, 3);
    end_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qbus_resp.md
# qbus_resp

Q-bus target (responder) for the F-11 test environment: the slave end of the bus driven by the processor wrapper. Decodes SYNC address phases against a configurable 22-bit window, serves DATI, DATO/DATOB and DATIO(B) cycles from a one-cycle-latency synchronous memory port, and answers IAKO interrupt-acknowledge cycles with a fixed vector. All bus pins are active-low, matching the processor side. RPLY is driven open-drain.

## Interface
- `BASE`, 22'o17760000: window base byte address; must be word-aligned to `2**(AW+1)`.
- `AW`, 12: memory word-address width; the window spans `2**(AW+1)` bytes.
- `IOPAGE`, 1: if 1, a hit additionally requires `BS` asserted; if 0, `BS` is ignored.
- `VECTOR`, 16'o000300: interrupt vector returned on IAKO.
- `RDLY`, 2: extra `pin_clk` cycles inserted before RPLY is asserted (0..15).
- `pin_clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high; clock `pin_clk`.
- `pin_init_n`, in, 1: bus INIT; when low, acts as a synchronous abort.
- `pin_ad_n`, inout, 16: inverted address/data bus.
- `pin_a_n`, in, 6 [21:16]: inverted high address bits.
- `pin_bs_n`, in, 1: I/O bank select.
- `pin_sync_n`, `pin_din_n`, `pin_dout_n`, `pin_wtbt_n`, `pin_iako_n`, in, 1 each: bus strobes.
- `pin_rply_n`, out, 1: reply; driven to 0 or Z only.
- `pin_virq_n`, out, 1: interrupt request, driven 0 or Z.
- `irq_set`, in, 1: pulse; sets the pending-interrupt flag.
- `mem_addr`, out, AW: memory word address.
- `mem_wdata`, out, 16: write data.
- `mem_be`, out, 2: byte enables.
- `mem_we`, out, 1: write strobe.
- `mem_re`, out, 1: read strobe.
- `mem_rdata`, in, 16: read data, valid exactly one cycle after `mem_re`.

## Operation
- Input sync: all strobes and `pin_init_n` pass through 2-flop synchronizers. AD, A and BS are sampled on the synchronized SYNC rising edge. The bus guarantees setup.
- FSM states:
  - IDLE
    - On SYNC edge: latch `addr = ~{a_n, ad_n}`, `bs`, and `wr = ~wtbt_n`.
    - Hit test: `addr[21:AW+1] == BASE[21:AW+1]`, plus `bs` if `IOPAGE`.
    - Hit -> SEL; miss -> NOSEL.
  - SEL: wait for a strobe.
    - DIN -> RD.
    - DOUT -> WR.
    - DIN and DOUT both asserted: stay in SEL and never reply; the master times out.
  - RD: pulse `mem_re` with `mem_addr = addr[AW:1]`; the next cycle latches `mem_rdata` -> DLY.
  - WR: latch `~ad_n` as data. Byte cycle if WTBT is asserted in the data phase:
    - `mem_be = addr[0] ? 2'b10 : 2'b01`;
    - byte data is replicated on both lanes;
    - otherwise `mem_be = 2'b11`.
    - Pulse `mem_we` -> DLY.
  - DLY: count `RDLY` cycles -> RPLY.
  - RPLY: assert RPLY. For a read, also drive `pin_ad_n = ~data`. Hold until the strobe negates, then release AD and RPLY -> SEL. This allows DATIO: a second DOUT under the same SYNC.
  - Any state: SYNC negation -> IDLE, with RPLY and AD released the same cycle.
  - NOSEL: wait for SYNC negation -> IDLE.
  - IACK: entered from IDLE when DIN and IAKO are asserted with SYNC negated and `pend` = 1.
    - Drive `~VECTOR` and RPLY.
    - Clear `pend`.
    - Hold until DIN negates -> IDLE.
    - IAKO with `pend` = 0: no response.
- `pend` handling:
  - Set by `irq_set`.
  - Cleared on IACK entry.
  - `pin_virq_n` = 0 while `pend` is set.
  - `irq_set` in the same cycle as IACK entry: `pend` stays 1.
- Abort: `reset` or synchronized INIT forces IDLE and clears `pend`.

## Timing
- Reset values:
  - `pin_rply_n` = Z, `pin_ad_n` = Z, `pin_virq_n` = Z.
  - `mem_we` = `mem_re` = 0, `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - State IDLE, `pend` = 0.
- Read latency, strobe pin edge to RPLY pin: 2 (sync) + 1 (RD) + 1 (data) + `RDLY` + 1 = `RDLY`+5 cycles.
- Write latency: `RDLY`+4 cycles.
- IACK latency: 3 cycles.
- Release: RPLY and AD are released 3 cycles after strobe negation (synchronizer plus 1).
- AD is never driven while DOUT is asserted or SYNC is negated, except in IACK.
- `mem_we` and `mem_re` are single-cycle pulses, one per data phase.

## Structure
- Package `qbus_pkg`:
  - FSM state enum (IDLE, SEL, NOSEL, RD, WR, DLY, RPLY, IACK);
  - strobe bit indices;
  - the hit-compare function.
- Sub-module `qbus_sync`: 2-flop synchronizer vector, instantiated once for the 6 strobes.

## Test plan
- DATI at `0o17760010`, memory word 4 = `0o123456`:
  - `mem_re` pulses with `mem_addr` = 4;
  - `pin_ad_n` = `~0o123456` while RPLY is asserted;
  - with `RDLY`=2, RPLY falls 7 cycles after DIN.
- DATOB to odd address `0o17760011`, data `0o000377`:
  - `mem_be` = 2'b10, `mem_wdata` = 16'o177777 (byte replicated);
  - RPLY asserted, then released 3 cycles after DOUT negates.
- DATIO: read then write under one SYNC at word 5 -> `mem_re` then `mem_we` each pulse once, with two RPLY pulses.
- Miss at `0o00001000`, and a hit address with BS negated (`IOPAGE`=1) -> no `mem_re`/`mem_we`; RPLY and AD stay Z.
- `irq_set`, then IAKO+DIN -> `pin_ad_n` = `~0o000300` with RPLY; `pend` cleared; a second IAKO gets no reply.
- INIT asserted mid-read in state DLY -> next synced cycle is IDLE with RPLY and AD Z; a following DATI completes normally.
